// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes and serial FSM states
package alu_pkg;
  typedef enum logic [1:0] {ALU_AND, ALU_OR, ALU_ADD, ALU_SLT} alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/alu_serial_if.sv
// alu_serial_if: request/response handshake bundle for the digit-serial ALU
interface alu_serial_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ainvert;
  logic             binvert;
  logic [1:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             cout;
  modport master (output in_valid, a, b, ainvert, binvert, operation, out_ready,
                  input in_ready, out_valid, result, zero, overflow, cout);
  modport slave (input in_valid, a, b, ainvert, binvert, operation, out_ready,
                 output in_ready, out_valid, result, zero, overflow, cout);
endinterface

// File: rtl/alu_digit.sv
// alu_digit: combinational DIGIT-bit ALU slice with ripple carry
module alu_digit import alu_pkg::*; #(parameter int DIGIT = 4) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic             cin,
  input  alu_op_e          operation,
  output logic [DIGIT-1:0] res,
  output logic             cout,
  output logic             c_msb
);
  logic [DIGIT-1:0] aa, bb, sum;
  // carry into the top bit is recovered from its sum bit for overflow detection
  always_comb begin
    aa = a ^ {DIGIT{ainvert}};
    bb = b ^ {DIGIT{binvert}};
    {cout, sum} = {1'b0, aa} + {1'b0, bb} + (DIGIT+1)'(cin);
    c_msb = aa[DIGIT-1] ^ bb[DIGIT-1] ^ sum[DIGIT-1];
    res = operation == ALU_AND ? aa & bb : operation == ALU_OR ? aa | bb : sum;
  end
endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU processing DIGIT bits per clock behind valid/ready
module alu_serial import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic         clk,
  input logic         rst,
  alu_serial_if.slave io
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_e           state;
  alu_op_e          op;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_next, fin;
  logic [CW-1:0]    cnt;
  logic             ai, bi, carry, zero_q, ovf_q, cout_q;
  logic [DIGIT-1:0] d_res;
  logic             d_cout, d_cmsb, ovf_n, arith, last;
  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a(a_sh[DIGIT-1:0]), .b(b_sh[DIGIT-1:0]), .ainvert(ai), .binvert(bi),
    .cin(carry), .operation(op), .res(d_res), .cout(d_cout), .c_msb(d_cmsb)
  );
  // next result image with the slice output entering at the top, plus SLT fixup
  always_comb begin
    res_next = (res >> DIGIT) | (WIDTH'(d_res) << (WIDTH - DIGIT));
    ovf_n = d_cmsb ^ d_cout;
    arith = op == ALU_ADD || op == ALU_SLT;
    fin = op == ALU_SLT ? WIDTH'(res_next[WIDTH-1] ^ ovf_n) : res_next;
    last = cnt == CW'(N - 1);
  end
  // control FSM, operand shift registers, carry and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op <= ALU_AND;
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      cnt <= '0;
      ai <= 1'b0;
      bi <= 1'b0;
      carry <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (io.in_valid) begin
          a_sh <= io.a;
          b_sh <= io.b;
          ai <= io.ainvert;
          bi <= io.binvert;
          op <= alu_op_e'(io.operation);
          carry <= io.binvert;
          cnt <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          carry <= d_cout;
          cnt <= cnt + 1'b1;
          res <= last ? fin : res_next;
          if (last) begin
            ovf_q <= arith & ovf_n;
            cout_q <= arith & d_cout;
            zero_q <= fin == '0;
            state <= S_DONE;
          end
        end
        S_DONE: if (io.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  assign io.in_ready  = state == S_IDLE;
  assign io.out_valid = state == S_DONE;
  assign io.result    = res;
  assign io.zero      = zero_q;
  assign io.overflow  = ovf_q;
  assign io.cout      = cout_q;
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: randomized and directed checks of alu_serial against an arithmetic model
module tb_alu_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  alu_serial_if #(.WIDTH(32)) bus ();
  alu_serial #(.WIDTH(32), .DIGIT(4)) dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [34:0] model(input logic [31:0] a, b, input logic ai, bi, input logic [1:0] op);
    logic [31:0] x, y, s, r;
    logic [32:0] t;
    logic v, c;
    x = ai ? ~a : a;
    y = bi ? ~b : b;
    t = {1'b0, x} + {1'b0, y} + {32'd0, bi};
    s = t[31:0];
    c = t[32];
    v = (x[31] == y[31]) && (s[31] != x[31]);
    case (op)
      2'b00: r = x & y;
      2'b01: r = x | y;
      2'b10: r = s;
      default: r = {31'd0, s[31] ^ v};
    endcase
    if (op[1] == 1'b0) begin
      v = 1'b0;
      c = 1'b0;
    end
    return {r, r == 32'd0, v, c};
  endfunction
  task automatic run_op(input logic [31:0] a, b, input logic ai, bi, input logic [1:0] op, input int hold);
    logic [34:0] e;
    int lat;
    e = model(a, b, ai, bi, op);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = a;
    bus.b = b;
    bus.ainvert = ai;
    bus.binvert = bi;
    bus.operation = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.ainvert = 1'($urandom);
    bus.binvert = 1'($urandom);
    bus.operation = 2'($urandom);
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'd9);
    chk("result", bus.result, e[34:3]);
    chk("zero", 32'(bus.zero), 32'(e[2]));
    chk("overflow", 32'(bus.overflow), 32'(e[1]));
    chk("cout", 32'(bus.cout), 32'(e[0]));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i == 1);
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_result", bus.result, e[34:3]);
      chk("hold_flags", {29'd0, bus.zero, bus.overflow, bus.cout}, {29'd0, e[2:0]});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.ainvert = 1'b0;
    bus.binvert = 1'b0;
    bus.operation = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flags", {29'd0, bus.zero, bus.overflow, bus.cout}, 32'd0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 2'b10, 0);
    run_op(32'd5, 32'd5, 1'b0, 1'b1, 2'b10, 0);
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 2'b11, 0);
    run_op(32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 2'b11, 0);
    run_op(32'hF0F0F0F0, 32'h0F0F0000, 1'b1, 1'b1, 2'b00, 0);
    run_op(32'h12345678, 32'h0000FFFF, 1'b0, 1'b0, 2'b01, 5);
    @(negedge clk);
    bus.a = 32'h11111111;
    bus.b = 32'h22222222;
    bus.ainvert = 1'b0;
    bus.binvert = 1'b0;
    bus.operation = 2'b10;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrun_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrun_result", bus.result, 32'd0);
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 2'b10, 0);
    for (int k = 0; k < 40; k++)
      run_op($urandom, (k % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
             1'($urandom), 1'($urandom), 2'($urandom), (k % 7 == 0) ? 2 : 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised multi-cycle ALU built as a digit-serial successor to the single-bit ALU slice.
- Processes a WIDTH-bit operation DIGIT bits per clock through one combinational DIGIT-bit slice chain, with a registered carry between digits.
- Supports AND/OR/ADD/SLT with A/B invert, giving SUB and NOR.
- Sits in the execute stage as an area-reduced ALU option behind a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ainvert  in  1  invert A before the operation.
- binvert  in  1  invert B before the operation; also LSB carry-in.
- operation  in  2  00 AND, 01 OR, 10 ADD, 11 SLT.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow of the add path.
- cout  out  1  carry out of the MSB.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - state=IDLE; in_ready=1; out_valid=0.
  - result, zero, overflow, cout = 0; carry register = 0; digit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b, ainvert, binvert, operation; carry := binvert; counter := 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the low DIGIT bits of the A/B shift registers pass through the digit slice with the registered carry.
  - Slice output shifts into the top of the result register; A/B shift right by DIGIT; carry := slice cout; counter++.
  - On the last digit (counter == N-1):
    - overflow := carry-into-MSB ^ carry-out-of-MSB.
    - cout := carry-out.
    - Apply SLT fixup.
    - Go to DONE.
- AND/OR: bitwise on (a^ainvert) and (b^binvert). The adder chain still runs but overflow and cout are forced to 0.
- ADD: sum of (a^ainvert) + (b^binvert) + binvert. SUB = binvert=1, op=10.
- SLT:
  - Full add runs as for ADD.
  - Final result = {WIDTH-1 zeros, sum_msb ^ overflow}.
  - overflow and cout reported from the subtraction.
- DONE:
  - out_valid=1; result and flags held stable until out_ready.
  - On out_ready: go to IDLE and clear out_valid.
  - in_ready=0, so no same-cycle accept. Throughput is one operation per N+2 cycles.
- zero is computed on the final result, after SLT fixup, and registered with it.
- Latency: accept at cycle 0 → out_valid high at cycle N+1 (9 for the defaults).
- Captured operands are immune to input changes after accept.
- in_valid while in_ready=0 is ignored; nothing is queued.
- rst asserted in any state (including mid-RUN or in DONE with out_valid high) discards the operation and returns all outputs to reset values on the next edge.
- WIDTH == DIGIT (N=1) is legal: one RUN cycle.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [1:0] alu_op_e {ALU_AND, ALU_OR, ALU_ADD, ALU_SLT}.
  - FSM state enum.
- One sub-module, alu_digit, is natural. It is a combinational DIGIT-bit ripple slice.
  - Inputs: a, b, ainvert, binvert, cin, operation.
  - Outputs: res[DIGIT], cout, c_msb (carry into its top bit, used for overflow).
- alu_serial contains the FSM, shift registers, counter, carry and flag registers.

Test Plan (WIDTH=32, DIGIT=4):
1. ADD: a=0x7FFFFFFF, b=0x00000001, op=10 → result=0x80000000, overflow=1, cout=0, zero=0; out_valid exactly 9 cycles after accept.
2. SUB: a=5, b=5, binvert=1, op=10 → result=0, zero=1, cout=1, overflow=0.
3. SLT:
   - a=0xFFFFFFFF, b=1, binvert=1, op=11 → result=1.
   - a=0x7FFFFFFF, b=0x80000000 (overflow case) → result=0, overflow=1.
4. NOR: a=0xF0F0F0F0, b=0x0F0F0000, ainvert=binvert=1, op=00 → result=0x00000F0F, overflow=0, cout=0.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid; pulse in_valid with other operands → result and flags stable, in_ready=0, the extra request ignored; out_ready=1 → IDLE next cycle.
6. Reset mid-RUN: assert rst on RUN cycle 4 → out_valid=0, in_ready=1 after the edge. A following ADD 3+4 returns 7 with normal latency.
